// File: rtl/traffic_pkg.sv
// Shared encodings for the highway/country traffic light controller and the
// blocks around it: light codes, request-conditioner state codes, and a helper
// that decides whether a country light value counts as red.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // State codes are fixed so controller-side checkers can decode state_dbg.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_SERVE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    REQ   = ST_REQ,
    SERVE = ST_SERVE
  } cond_state_e;

  // Code 3 is not a legal light; it is treated as red.
  function automatic logic light_is_red(input logic [1:0] light);
    return (light != YELLOW) && (light != GREEN);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser and tick-based debouncer for the country loop
// detector. Emits a one-cycle arrive pulse on each debounced 0->1 edge.
module sensor_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic tick,
  input  logic sensor_raw,
  output logic arrive
);

  localparam logic [3:0] CNT_LAST = 4'(DEB_TICKS - 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic       level_d;
  logic [3:0] deb_cnt;

  // Bring the asynchronous detector into the clk domain.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive ticks on which the synchronised level disagrees with
  // the debounced level; adopt the new level once it has held long enough.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      level   <= 1'b0;
      deb_cnt <= 4'd0;
    end else if (tick) begin
      if (sync2 != level) begin
        if (deb_cnt == CNT_LAST) begin
          level   <= sync2;
          deb_cnt <= 4'd0;
        end else begin
          deb_cnt <= deb_cnt + 4'd1;
        end
      end else begin
        deb_cnt <= 4'd0;
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) level_d <= 1'b0;
    else          level_d <= level;
  end

  assign arrive = level & ~level_d;

endmodule

// File: rtl/cntry_sensor_cond.sv
// Country-road request conditioner. Debounces the loop detector, latches
// arrivals, enforces a minimum highway green, and raises the request x.
// Optional served-request counter is built when CNTRY_SERVE_CNT_EN is defined.
//
// Request protocol: x is a level request. It rises only after a latched
// arrival and a full minimum highway green, and is held until the controller
// acknowledges it by showing country green, after which x drops on the next clk.
module cntry_sensor_cond #(
  parameter int DEB_TICKS     = 4,
  parameter int MIN_HWY_TICKS = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick,
  input  logic       sensor_raw,
  input  logic [1:0] cntry_light,
  output logic       x,
  output logic       car_waiting,
  output logic [7:0] serve_cnt,
  output logic [1:0] state_dbg
);

  import traffic_pkg::*;

  localparam logic [CNT_W-1:0] HWY_FULL = CNT_W'(MIN_HWY_TICKS);

  cond_state_e      state;
  cond_state_e      state_n;
  logic             rearm;
  logic             rearm_n;
  logic             arrive;
  logic             light_red;
  logic             hwy_full;
  logic [CNT_W-1:0] hwy_cnt;

  sensor_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_debounce (
    .clk        (clk),
    .clear_n    (clear_n),
    .tick       (tick),
    .sensor_raw (sensor_raw),
    .arrive     (arrive)
  );

  assign light_red = light_is_red(cntry_light);
  assign hwy_full  = (hwy_cnt == HWY_FULL);
  assign state_dbg = state;

  // Minimum highway green: count red ticks, restart whenever country is not red.
  // Preset full so a cold start may request immediately.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                  hwy_cnt <= HWY_FULL;
    else if (!light_red)           hwy_cnt <= '0;
    else if (tick && !hwy_full)    hwy_cnt <= hwy_cnt + 1'b1;
  end

  // State, rearm flag and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      rearm       <= 1'b0;
      x           <= 1'b0;
      car_waiting <= 1'b0;
    end else begin
      state       <= state_n;
      rearm       <= rearm_n;
      x           <= (state_n == REQ);
      car_waiting <= (state_n == ARMED) || (state_n == REQ);
    end
  end

  // Next-state logic. Green in REQ wins over a simultaneous arrival; an
  // arrival seen while being served (including on the red cycle) re-arms.
  always_comb begin
    state_n = state;
    rearm_n = rearm;
    case (state)
      IDLE:  if (arrive) state_n = ARMED;
      ARMED: if (hwy_full) state_n = REQ;
      REQ:   if (cntry_light == GREEN) state_n = SERVE;
      SERVE: begin
        if (light_red) begin
          state_n = (rearm || arrive) ? ARMED : IDLE;
          rearm_n = 1'b0;
        end else if (arrive) begin
          rearm_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CNTRY_SERVE_CNT_EN
  logic [7:0] serve_q;

  // Count REQ->SERVE handoffs, saturating at 255.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      serve_q <= 8'd0;
    else if ((state == REQ) && (state_n == SERVE) && (serve_q != 8'hFF))
      serve_q <= serve_q + 8'd1;
  end

  assign serve_cnt = serve_q;
`else
  assign serve_cnt = 8'd0;
`endif

endmodule
